status_flag_unit: RTL and testbench
===================================

// Module: status_flag_unit
// PURPOSE
//  Owns the architectural NZCV status register and feeds the ID-stage condition evaluator.
//  Tracks flag-setting instructions between issue (ID) and flag commit.
//  Raises a hazard stall when a conditional instruction in ID would read stale flags.
//  Optionally bypasses flags in their commit cycle.
//  Sits between ID (issue, condition evaluation) and the commit stage that produces ALU NZCV.
// PARAMETERS
//  LAT     1  cycles from issue of a flag-setting instr in ID to its commit strobe (range 1..4)
//  BYPASS  1  1: forward commit-cycle flags to sr_id; 0: stall until flags are registered
// PORTS
//  clk          in   1  system clock, all state on posedge
//  rst          in   1  synchronous reset, active-high
//  freeze       in   1  global pipeline hold (memory stall); all state holds
//  flush        in   1  kill the instruction currently in ID (branch taken)
//  id_valid     in   1  ID holds a valid instruction
//  id_s         in   1  ID instruction sets flags (S bit)
//  id_cond      in   4  ID instruction condition field
//  wb_s         in   1  commit strobe: flags of an in-flight S instr arrive this cycle
//  wb_status    in   4  committed flags {N,Z,C,V}
//  sr           out  4  architectural NZCV, registered
//  sr_id        out  4  flags presented to the ID condition evaluator
//  flag_hazard  out  1  stall ID/IF this cycle
//  issue_s      out  1  a flag-setting instr leaves ID this cycle
//  pend_any     out  1  at least one flag write is in flight
//  sr_err       out  1  sticky: commit strobe / tracking mismatch
// BEHAVIOUR
//  Reset (rst=1 at posedge): sr=4'b0, pend[LAT-1:0]=0, sr_err=0.
//  reads_flags = id_valid & (id_cond < 4'd14). Conditions AL=14 and NV=15 never read flags.
//  Pending pipe pend[0..LAT-1], one bit per in-flight flag writer:
//   - when ~freeze: pend[0]<=issue_s; pend[i]<=pend[i-1].
//   - when freeze: pend holds.
//  byp_ok = BYPASS & wb_s & ~freeze.
//  older  = |pend[LAT-2:0]; empty when LAT=1.
//  flag_hazard = reads_flags & (older | (pend[LAT-1] & ~byp_ok)). Combinational.
//  issue_s = id_valid & id_s & ~flag_hazard & ~freeze & ~flush.
//  flush gates issue only; older writers already in flight still commit.
//  Commit: if wb_s & ~freeze then sr<=wb_status, else sr holds. Commit applies in the same edge it is strobed.
//  sr_id = byp_ok ? wb_status : sr. Combinational, no added latency.
//  Check: wb_s must equal pend[LAT-1] whenever ~freeze; a mismatch sets sr_err (cleared only by rst).
//  A conditional instr in ID behind an S instr in flight stalls:
//   - LAT-1 cycles with BYPASS=1;
//   - LAT cycles with BYPASS=0.
//  Back-to-back S instrs with no flag reader: no stall; commits occur in order.
//  freeze and flush together: freeze wins, all state holds.
//  rst mid-flight discards pending writes. Later wb_s pulses for discarded writes set sr_err; the pipeline must also be reset.
// STRUCTURE
//  Shared package: NZCV bit indices N=3,Z=2,C=1,V=0; 4-bit condition-code constants EQ=0..AL=14,NV=15.
//  Sub-module flag_pending_pipe: the LAT-deep pend shift register with freeze. Exports pend vector.
//  Top level holds sr, hazard and bypass logic, and the error check.
// TESTING
//  1. rst=1 for 1 cycle -> sr=0000, flag_hazard=0, pend_any=0, sr_err=0.
//  2. LAT=1, BYPASS=1: S instr issued; next cycle wb_s=1, wb_status=0100, ID cond=EQ(0)
//     -> flag_hazard=0, sr_id=0100, sr=0100 after edge.
//  3. LAT=2, BYPASS=0: S instr then cond=NE(1) in ID -> flag_hazard=1 for 2 cycles; sr_id=new flags on 3rd.
//  4. freeze=1 for 3 cycles mid-flight -> pend, sr hold; commit lands after freeze drops; sr_err stays 0.
//  5. flush=1 with id_s=1, id_valid=1 -> issue_s=0, pend_any stays 0; a wb_s pulse later sets sr_err=1.
//  6. cond=AL(14) behind a pending S instr -> flag_hazard=0; sr_id=sr.

Source files
------------

// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the NZCV status flag unit: flag bit positions,
// condition-code encodings and the "does this condition read flags" helper.
package status_flag_unit_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // AL and NV are unconditional in this pipeline, so they never consume flags.
    function automatic logic cond_reads_flags(input logic [3:0] cond);
        return cond < COND_AL;
    endfunction

endpackage

// File: rtl/status_flag_unit_if.sv
// Bundle between the ID/commit stages and the status flag unit.
// The slave side is the flag unit itself; the master side is the pipeline.
interface status_flag_unit_if;
    logic       freeze;
    logic       flush;
    logic       id_valid;
    logic       id_s;
    logic [3:0] id_cond;
    logic       wb_s;
    logic [3:0] wb_status;
    logic [3:0] sr;
    logic [3:0] sr_id;
    logic       flag_hazard;
    logic       issue_s;
    logic       pend_any;
    logic       sr_err;

    modport slave (
        input  freeze, flush, id_valid, id_s, id_cond, wb_s, wb_status,
        output sr, sr_id, flag_hazard, issue_s, pend_any, sr_err
    );

    modport master (
        output freeze, flush, id_valid, id_s, id_cond, wb_s, wb_status,
        input  sr, sr_id, flag_hazard, issue_s, pend_any, sr_err
    );
endinterface

// File: rtl/status_flag_unit_flag_pending_pipe.sv
// LAT-deep shift register of in-flight flag writers; bit LAT-1 is the one
// whose commit strobe is due this cycle. Holds completely while frozen.
module status_flag_unit_flag_pending_pipe #(
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           freeze_i,
    input  logic           issue_i,
    output logic [LAT-1:0] pend_o
);

    logic [LAT-1:0] pend_q;
    logic [LAT-1:0] pend_d;
    logic [LAT-1:0] shift_in;

    assign shift_in[0] = issue_i;

    generate
        for (genvar gi = 1; gi < LAT; gi++) begin : g_shift
            assign shift_in[gi] = pend_q[gi-1];
        end
    endgenerate

    assign pend_d = freeze_i ? pend_q : shift_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/status_flag_unit.sv
// Architectural NZCV register with in-flight writer tracking, ID-stage flag
// hazard detection, optional commit-cycle bypass and a sticky tracking error.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int LAT    = 1,
    parameter int BYPASS = 1
) (
    input logic               clk,
    input logic               rst,
    status_flag_unit_if.slave sfu
);

    localparam logic BYP_EN = (BYPASS != 0);

    logic [LAT-1:0] pend;
    logic           reads_flags;
    logic           older;
    logic           byp_ok;
    logic           hazard;
    logic           issue;
    logic [3:0]     sr_q;
    logic [3:0]     sr_d;
    logic           err_q;
    logic           err_d;

    status_flag_unit_flag_pending_pipe #(
        .LAT (LAT)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .freeze_i (sfu.freeze),
        .issue_i  (issue),
        .pend_o   (pend)
    );

    // Writers younger than the head are too far away for any bypass to help.
    generate
        if (LAT > 1) begin : g_older
            assign older = |pend[LAT-2:0];
        end else begin : g_no_older
            assign older = 1'b0;
        end
    endgenerate

    assign reads_flags = sfu.id_valid & cond_reads_flags(sfu.id_cond);
    assign byp_ok      = BYP_EN & sfu.wb_s & ~sfu.freeze;
    assign hazard      = reads_flags & (older | (pend[LAT-1] & ~byp_ok));
    assign issue       = sfu.id_valid & sfu.id_s & ~hazard & ~sfu.freeze & ~sfu.flush;

    always_comb begin
        sr_d = sr_q;
        if (sfu.wb_s && !sfu.freeze) begin
            sr_d = sfu.wb_status;
        end
    end

    // The strobe must line up exactly with the tracked head writer.
    assign err_d = err_q | (~sfu.freeze & (sfu.wb_s != pend[LAT-1]));

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= 4'b0000;
            err_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            err_q <= err_d;
        end
    end

    assign sfu.sr          = sr_q;
    assign sfu.sr_id       = byp_ok ? sfu.wb_status : sr_q;
    assign sfu.flag_hazard = hazard;
    assign sfu.issue_s     = issue;
    assign sfu.pend_any    = |pend;
    assign sfu.sr_err      = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: one LAT=1/BYPASS=1 instance and one
// LAT=2/BYPASS=0 instance, expectations queued per step and checked after settle.
module tb_status_flag_unit;

    logic clk;
    logic rst;

    int checks;
    int errors;

    status_flag_unit_if bus1 ();
    status_flag_unit_if bus2 ();

    status_flag_unit #(.LAT(1), .BYPASS(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .sfu (bus1.slave)
    );

    status_flag_unit #(.LAT(2), .BYPASS(0)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .sfu (bus2.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        string      tag;
        logic [3:0] sr;
        logic [3:0] sr_id;
        logic       haz;
        logic       iss;
        logic       pany;
        logic       err;
    } exp_t;

    exp_t sb[$];

    task automatic drv1(input logic iv, input logic is, input logic [3:0] c,
                        input logic fr, input logic fl, input logic ws, input logic [3:0] wst);
        bus1.id_valid  = iv;
        bus1.id_s      = is;
        bus1.id_cond   = c;
        bus1.freeze    = fr;
        bus1.flush     = fl;
        bus1.wb_s      = ws;
        bus1.wb_status = wst;
    endtask

    task automatic drv2(input logic iv, input logic is, input logic [3:0] c,
                        input logic fr, input logic fl, input logic ws, input logic [3:0] wst);
        bus2.id_valid  = iv;
        bus2.id_s      = is;
        bus2.id_cond   = c;
        bus2.freeze    = fr;
        bus2.flush     = fl;
        bus2.wb_s      = ws;
        bus2.wb_status = wst;
    endtask

    task automatic expect_step(input int d, input string tag, input logic [3:0] sr,
                               input logic [3:0] sr_id, input logic haz, input logic iss,
                               input logic pany, input logic err);
        exp_t e;
        e.dut = d; e.tag = tag; e.sr = sr; e.sr_id = sr_id;
        e.haz = haz; e.iss = iss; e.pany = pany; e.err = err;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_front();
        exp_t e;
        logic [3:0] o_sr, o_srid;
        logic       o_haz, o_iss, o_pany, o_err;
        e = sb.pop_front();
        if (e.dut == 1) begin
            o_sr = bus1.sr; o_srid = bus1.sr_id; o_haz = bus1.flag_hazard;
            o_iss = bus1.issue_s; o_pany = bus1.pend_any; o_err = bus1.sr_err;
        end else begin
            o_sr = bus2.sr; o_srid = bus2.sr_id; o_haz = bus2.flag_hazard;
            o_iss = bus2.issue_s; o_pany = bus2.pend_any; o_err = bus2.sr_err;
        end
        cmp({e.tag, ".sr"},          o_sr,           e.sr);
        cmp({e.tag, ".sr_id"},       o_srid,         e.sr_id);
        cmp({e.tag, ".flag_hazard"}, {3'b0, o_haz},  {3'b0, e.haz});
        cmp({e.tag, ".issue_s"},     {3'b0, o_iss},  {3'b0, e.iss});
        cmp({e.tag, ".pend_any"},    {3'b0, o_pany}, {3'b0, e.pany});
        cmp({e.tag, ".sr_err"},      {3'b0, o_err},  {3'b0, e.err});
        $display("step dut%0d %s sr=%b sr_id=%b haz=%b iss=%b pend=%b err=%b",
                 e.dut, e.tag, o_sr, o_srid, o_haz, o_iss, o_pany, o_err);
    endtask

    task automatic settle_check();
        #1;
        while (sb.size() > 0) check_front();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        drv1(0, 0, 4'd0, 0, 0, 0, 4'd0);
        drv2(0, 0, 4'd0, 0, 0, 0, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        expect_step(1, "reset", 4'b0000, 4'b0000, 0, 0, 0, 0);
        expect_step(2, "reset", 4'b0000, 4'b0000, 0, 0, 0, 0);
        settle_check();

        // LAT=1 BYPASS=1: S instr, then EQ reader in the commit cycle
        @(negedge clk);
        drv1(1, 1, 4'd14, 0, 0, 0, 4'b0000);
        expect_step(1, "byp_issue", 4'b0000, 4'b0000, 0, 1, 0, 0);
        settle_check();
        @(negedge clk);
        drv1(1, 0, 4'd0, 0, 0, 1, 4'b0100);
        expect_step(1, "byp_commit", 4'b0000, 4'b0100, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv1(0, 0, 4'd0, 0, 0, 0, 4'b0000);
        expect_step(1, "byp_after", 4'b0100, 4'b0100, 0, 0, 0, 0);
        settle_check();

        // LAT=2 BYPASS=0: NE reader stalls two cycles
        @(negedge clk);
        drv2(1, 1, 4'd14, 0, 0, 0, 4'b0000);
        expect_step(2, "stall_issue", 4'b0000, 4'b0000, 0, 1, 0, 0);
        settle_check();
        @(negedge clk);
        drv2(1, 0, 4'd1, 0, 0, 0, 4'b0000);
        expect_step(2, "stall_c1", 4'b0000, 4'b0000, 1, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(1, 0, 4'd1, 0, 0, 1, 4'b1010);
        expect_step(2, "stall_c2", 4'b0000, 4'b0000, 1, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(1, 0, 4'd1, 0, 0, 0, 4'b0000);
        expect_step(2, "stall_c3", 4'b1010, 4'b1010, 0, 0, 0, 0);
        settle_check();

        // AL behind pending S instr never stalls
        @(negedge clk);
        drv2(1, 1, 4'd14, 0, 0, 0, 4'b0000);
        expect_step(2, "al_issue", 4'b1010, 4'b1010, 0, 1, 0, 0);
        settle_check();
        @(negedge clk);
        drv2(1, 0, 4'd14, 0, 0, 0, 4'b0000);
        expect_step(2, "al_p1", 4'b1010, 4'b1010, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(1, 0, 4'd14, 0, 0, 1, 4'b0001);
        expect_step(2, "al_p2", 4'b1010, 4'b1010, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(0, 0, 4'd0, 0, 0, 0, 4'b0000);
        expect_step(2, "al_done", 4'b0001, 4'b0001, 0, 0, 0, 0);
        settle_check();

        // Freeze for 3 cycles mid-flight
        @(negedge clk);
        drv2(1, 1, 4'd14, 0, 0, 0, 4'b0000);
        expect_step(2, "frz_issue", 4'b0001, 4'b0001, 0, 1, 0, 0);
        settle_check();
        @(negedge clk);
        drv2(1, 1, 4'd14, 1, 0, 0, 4'b0000);
        expect_step(2, "frz_f1", 4'b0001, 4'b0001, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(0, 0, 4'd0, 1, 1, 1, 4'b1111);
        expect_step(2, "frz_f2", 4'b0001, 4'b0001, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(0, 0, 4'd0, 1, 0, 0, 4'b0000);
        expect_step(2, "frz_f3", 4'b0001, 4'b0001, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(0, 0, 4'd0, 0, 0, 0, 4'b0000);
        expect_step(2, "frz_rel", 4'b0001, 4'b0001, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(0, 0, 4'd0, 0, 0, 1, 4'b0110);
        expect_step(2, "frz_commit", 4'b0001, 4'b0001, 0, 0, 1, 0);
        settle_check();
        @(negedge clk);
        drv2(0, 0, 4'd0, 0, 0, 0, 4'b0000);
        expect_step(2, "frz_done", 4'b0110, 4'b0110, 0, 0, 0, 0);
        settle_check();

        // Flush kills issue; a stray strobe later trips sr_err
        @(negedge clk);
        drv1(1, 1, 4'd14, 0, 1, 0, 4'b0000);
        expect_step(1, "flush_kill", 4'b0100, 4'b0100, 0, 0, 0, 0);
        settle_check();
        @(negedge clk);
        drv1(0, 0, 4'd0, 0, 0, 0, 4'b0000);
        expect_step(1, "flush_idle", 4'b0100, 4'b0100, 0, 0, 0, 0);
        settle_check();
        @(negedge clk);
        drv1(0, 0, 4'd0, 0, 0, 1, 4'b1100);
        expect_step(1, "flush_stray", 4'b0100, 4'b1100, 0, 0, 0, 0);
        settle_check();
        @(negedge clk);
        drv1(0, 0, 4'd0, 0, 0, 0, 4'b0000);
        expect_step(1, "flush_err", 4'b1100, 4'b1100, 0, 0, 0, 1);
        settle_check();

        // Reset clears the sticky error and the register
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_step(1, "rst_clear", 4'b0000, 4'b0000, 0, 0, 0, 0);
        expect_step(2, "rst_clear", 4'b0000, 4'b0000, 0, 0, 0, 0);
        settle_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
